// File: rtl/sistema_scan_pkg.sv
// sistema_scan_pkg: shared state encoding, default widths and the
// hash-versus-target compare used by the nonce-search controller.
package sistema_scan_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CHECK   = 3'd3,
    ST_HIT     = 3'd4,
    ST_EXHAUST = 3'd5
  } state_t;

  // Default configuration of the search loop
  localparam int DEF_LOG_LANES = 3;
  localparam int DEF_NONCE_W   = 32;
  localparam int DEF_HASH_W    = 24;
  localparam int DEF_CMP_BYTES = 2;
  localparam int BATCH_W       = 32;

  // Widest hash the compare helper accepts; narrower hashes are zero-extended
  localparam int MAX_HASH_W     = 256;
  localparam int MAX_HASH_BYTES = MAX_HASH_W / 8;

  // A hash hits when each of its top cmp_bytes bytes is strictly below
  // target. Bytes are counted from the most-significant byte of a
  // hash_bytes-wide hash, so a zero target can never hit.
  function automatic logic hash_below_target(
    input logic [MAX_HASH_W-1:0] hash,
    input int                    hash_bytes,
    input int                    cmp_bytes,
    input logic [7:0]            target
  );
    logic hit;
    logic in_range;
    int   idx;
    hit = 1'b1;
    for (int b = 0; b < MAX_HASH_BYTES; b++) begin
      in_range = (b < cmp_bytes) && (b < hash_bytes);
      idx      = in_range ? (hash_bytes - 1 - b) : 0;
      hit      = hit & (!in_range | (hash[idx*8 +: 8] < target));
    end
    return hit;
  endfunction

endpackage

// File: rtl/sistema_scan_hit_pick.sv
// scan_hit_pick: priority encoder returning the lowest set lane of a hit mask.
module scan_hit_pick
  import sistema_scan_pkg::*;
#(
  parameter int LANES = 8,
  parameter int IDX_W = 3
) (
  input  logic [LANES-1:0] mask,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top so the lowest set lane is the last one written
  always_comb begin
    found = 1'b0;
    idx   = {IDX_W{1'b0}};
    for (int i = LANES - 1; i >= 0; i--) begin
      idx   = mask[i] ? IDX_W'(i) : idx;
      found = found | mask[i];
    end
  end

endmodule

// File: rtl/sistema_scan.sv
// sistema_scan: issues batches of consecutive nonces to external hash lanes,
// screens the returned hashes against an 8-bit target and reports hits in
// stop-on-first or continuous mode, flagging exhaustion of the nonce space.
module sistema_scan
  import sistema_scan_pkg::*;
#(
  parameter int LOG_LANES = DEF_LOG_LANES,
  parameter int NONCE_W   = DEF_NONCE_W,
  parameter int HASH_W    = DEF_HASH_W,
  parameter int CMP_BYTES = DEF_CMP_BYTES
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              active,
  input  logic                              mode,
  input  logic [7:0]                        target,
  input  logic [NONCE_W-1:0]                nonce_base,
  input  logic                              result_ack,
  output logic                              lane_start,
  output logic [(2**LOG_LANES)*NONCE_W-1:0] lane_nonce,
  input  logic                              lane_done,
  input  logic [(2**LOG_LANES)*HASH_W-1:0]  lane_hash,
  output logic                              terminado,
  output logic [HASH_W-1:0]                 hashOut,
  output logic [NONCE_W-1:0]                nonceOut,
  output logic                              exhausted,
  output logic [BATCH_W-1:0]                batches
);

  localparam int LANES      = 2 ** LOG_LANES;
  localparam int HASH_BYTES = HASH_W / 8;
  // Last aligned batch base; also the mask that aligns nonce_base
  localparam logic [NONCE_W-1:0] TOP_BASE = {NONCE_W{1'b1}} << LOG_LANES;

  state_t state_r, state_next_s;

  logic [7:0]              target_r;
  logic                    mode_r;
  logic [NONCE_W-1:0]      base_r;
  logic [LANES*HASH_W-1:0] hash_r;
  logic [LANES-1:0]        hit_mask_r;
  logic                    lane_start_r;
  logic [LANES*NONCE_W-1:0] lane_nonce_r;
  logic                    terminado_r;
  logic [HASH_W-1:0]       hash_out_r;
  logic [NONCE_W-1:0]      nonce_out_r;
  logic                    exhausted_r;
  logic [BATCH_W-1:0]      batches_r;

  logic                     start_s, launch_s, capture_s, report_s;
  logic                     exhaust_s, ack_s, abort_s;
  logic [NONCE_W-1:0]       base_next_s;
  logic [LANES*NONCE_W-1:0] nonce_vec_s;
  logic [LANES-1:0]         hit_vec_s;
  logic                     pick_found_s;
  logic [LOG_LANES-1:0]     pick_idx_s;

  scan_hit_pick #(
    .LANES (LANES),
    .IDX_W (LOG_LANES)
  ) u_hit_pick (
    .mask  (hit_mask_r),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; dropping active returns to IDLE from anywhere
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:    state_next_s = active ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:   state_next_s = active ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        if (!active) begin
          state_next_s = ST_IDLE;
        end else if (lane_done) begin
          state_next_s = ST_CHECK;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_CHECK: begin
        if (!active) begin
          state_next_s = ST_IDLE;
        end else if (pick_found_s) begin
          state_next_s = ST_HIT;
        end else if (base_r == TOP_BASE) begin
          state_next_s = ST_EXHAUST;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_HIT: begin
        if (!active) begin
          state_next_s = ST_IDLE;
        end else if (mode_r && result_ack) begin
          state_next_s = ST_CHECK;
        end else begin
          state_next_s = ST_HIT;
        end
      end
      ST_EXHAUST: state_next_s = active ? ST_EXHAUST : ST_IDLE;
      default:    state_next_s = ST_IDLE;
    endcase
  end

  // Output decode: one-cycle strobes that steer the registered datapath
  always_comb begin
    start_s     = 1'b0;
    launch_s    = 1'b0;
    capture_s   = 1'b0;
    report_s    = 1'b0;
    exhaust_s   = 1'b0;
    ack_s       = 1'b0;
    base_next_s = base_r + NONCE_W'(LANES);
    case (state_r)
      ST_IDLE: begin
        base_next_s = nonce_base & TOP_BASE;
        start_s     = active;
        launch_s    = active;
      end
      ST_WAIT:  capture_s = active & lane_done;
      ST_CHECK: begin
        report_s  = active & pick_found_s;
        exhaust_s = active & ~pick_found_s & (base_r == TOP_BASE);
        launch_s  = active & ~pick_found_s & (base_r != TOP_BASE);
      end
      ST_HIT:   ack_s = active & mode_r & result_ack;
      default:  ack_s = 1'b0;
    endcase
    abort_s = (state_r != ST_IDLE) & ~active;
  end

  // Nonces for the batch about to be launched
  always_comb begin
    nonce_vec_s = '0;
    for (int i = 0; i < LANES; i++) begin
      nonce_vec_s[i*NONCE_W +: NONCE_W] = base_next_s + NONCE_W'(i);
    end
  end

  // Per-lane screen of the returning hashes against the captured target
  always_comb begin
    hit_vec_s = '0;
    for (int i = 0; i < LANES; i++) begin
      hit_vec_s[i] = hash_below_target(MAX_HASH_W'(lane_hash[i*HASH_W +: HASH_W]),
                                       HASH_BYTES, CMP_BYTES, target_r);
    end
  end

  // Search context: captured config, batch base, lane results and hit mask
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_r     <= 8'h00;
      mode_r       <= 1'b0;
      base_r       <= '0;
      hash_r       <= '0;
      hit_mask_r   <= '0;
      lane_start_r <= 1'b0;
      lane_nonce_r <= '0;
      batches_r    <= '0;
    end else begin
      lane_start_r <= launch_s;
      if (start_s) begin
        target_r <= target;
        mode_r   <= mode;
      end
      if (launch_s) begin
        base_r       <= base_next_s;
        lane_nonce_r <= nonce_vec_s;
        batches_r    <= batches_r + 32'd1;
      end
      if (capture_s) begin
        hash_r     <= lane_hash;
        hit_mask_r <= hit_vec_s;
      end else if (ack_s) begin
        hit_mask_r[pick_idx_s] <= 1'b0;
      end
    end
  end

  // Result reporting; hashOut/nonceOut keep their value across an abort
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      terminado_r <= 1'b0;
      hash_out_r  <= '0;
      nonce_out_r <= '0;
      exhausted_r <= 1'b0;
    end else begin
      if (report_s) begin
        hash_out_r  <= hash_r[pick_idx_s*HASH_W +: HASH_W];
        nonce_out_r <= base_r + NONCE_W'(pick_idx_s);
        terminado_r <= 1'b1;
      end else if (ack_s || abort_s) begin
        terminado_r <= 1'b0;
      end
      if (exhaust_s) begin
        exhausted_r <= 1'b1;
      end else if (abort_s) begin
        exhausted_r <= 1'b0;
      end
    end
  end

  assign lane_start = lane_start_r;
  assign lane_nonce = lane_nonce_r;
  assign terminado  = terminado_r;
  assign hashOut    = hash_out_r;
  assign nonceOut   = nonce_out_r;
  assign exhausted  = exhausted_r;
  assign batches    = batches_r;

endmodule

// File: tb/tb_sistema_scan.sv
// tb_sistema_scan: directed bench for the nonce-search controller with a
// 5-cycle behavioural lane model (4 lanes, 2-byte compare).
module tb_sistema_scan;

  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         reset, active, mode, result_ack, lane_done;
  logic [7:0]   target;
  logic [31:0]  nonce_base;
  logic [95:0]  lane_hash;
  logic         lane_start, terminado, exhausted;
  logic [127:0] lane_nonce;
  logic [23:0]  hash_out;
  logic [31:0]  nonce_out, batches;

  logic         active8, lane_done8;
  logic [7:0]   nonce_base8;
  logic [95:0]  lane_hash8;
  logic         lane_start8, terminado8, exhausted8;
  logic [31:0]  lane_nonce8;
  logic [23:0]  hash_out8;
  logic [7:0]   nonce_out8;
  logic [31:0]  batches8;

  int checks = 0;
  int errors = 0;

  // Nonces that the lane model hashes to something other than all-ones
  logic [31:0] ha, hb, nr;

  sistema_scan #(.LOG_LANES(2), .NONCE_W(32), .HASH_W(24), .CMP_BYTES(2)) dut (
    .clk(clk), .reset(reset), .active(active), .mode(mode), .target(target),
    .nonce_base(nonce_base), .result_ack(result_ack), .lane_start(lane_start),
    .lane_nonce(lane_nonce), .lane_done(lane_done), .lane_hash(lane_hash),
    .terminado(terminado), .hashOut(hash_out), .nonceOut(nonce_out),
    .exhausted(exhausted), .batches(batches)
  );

  sistema_scan #(.LOG_LANES(2), .NONCE_W(8), .HASH_W(24), .CMP_BYTES(2)) dut8 (
    .clk(clk), .reset(reset), .active(active8), .mode(mode), .target(target),
    .nonce_base(nonce_base8), .result_ack(result_ack), .lane_start(lane_start8),
    .lane_nonce(lane_nonce8), .lane_done(lane_done8), .lane_hash(lane_hash8),
    .terminado(terminado8), .hashOut(hash_out8), .nonceOut(nonce_out8),
    .exhausted(exhausted8), .batches(batches8)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] model_hash(input logic [31:0] n);
    if (n == ha) return {8'h0F, 8'h0F, n[7:0]};
    else if (n == hb) return {8'h0E, 8'h00, n[7:0]};
    else if (n == nr) return {8'h0F, 8'h10, n[7:0]};
    else return 24'hFF_FFFF;
  endfunction

  // Lane model for the 32-bit instance: done pulse 5 cycles after launch
  int          cnt;
  logic [127:0] pend;
  always @(negedge clk) begin
    lane_done = 1'b0;
    if (reset) cnt = 0;
    else if (lane_start) begin
      cnt  = 5;
      pend = lane_nonce;
    end else if (cnt != 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        lane_done = 1'b1;
        for (int i = 0; i < 4; i++) lane_hash[i*24 +: 24] = model_hash(pend[i*32 +: 32]);
      end
    end
  end

  // Lane model for the 8-bit instance: never hits
  int cnt8;
  always @(negedge clk) begin
    lane_done8 = 1'b0;
    if (reset) cnt8 = 0;
    else if (lane_start8) cnt8 = 5;
    else if (cnt8 != 0) begin
      cnt8 = cnt8 - 1;
      if (cnt8 == 0) lane_done8 = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    active = 1'b0; active8 = 1'b0; result_ack = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_term(input string name);
    int n = 0;
    while (terminado !== 1'b1 && n < 200) begin tick(); n++; end
    chk(name, terminado, 1'b1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (lane_done !== 1'b1 && n < 40) begin tick(); n++; end
    chk(name, lane_done, 1'b1);
  endtask

  typedef struct {
    logic [31:0]  base;
    logic [7:0]   tgt;
    logic [31:0]  ha, hb, nr;
    logic         exp_hit;
    logic [31:0]  exp_nonce;
    logic [23:0]  exp_hash;
    logic [31:0]  exp_batches;
    logic [127:0] exp_first;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int nb, t, t_done, t_exh, starts;
    logic [31:0] last8;

    vecs[0] = '{32'h00, 8'h10, 32'h06, NONE, NONE, 1'b1, 32'h06, 24'h0F0F06, 32'd2,
                {32'h03, 32'h02, 32'h01, 32'h00}};
    vecs[1] = '{32'h13, 8'h10, 32'h15, NONE, NONE, 1'b1, 32'h15, 24'h0F0F15, 32'd2,
                {32'h13, 32'h12, 32'h11, 32'h10}};
    vecs[2] = '{32'h20, 8'h10, 32'h22, NONE, 32'h21, 1'b1, 32'h22, 24'h0F0F22, 32'd1,
                {32'h23, 32'h22, 32'h21, 32'h20}};
    vecs[3] = '{32'h30, 8'h0F, 32'h31, 32'h36, NONE, 1'b1, 32'h36, 24'h0E0036, 32'd2,
                {32'h33, 32'h32, 32'h31, 32'h30}};
    vecs[4] = '{32'h40, 8'h00, 32'h42, 32'h41, NONE, 1'b0, 32'h00, 24'h000000, 32'd0,
                {32'h43, 32'h42, 32'h41, 32'h40}};

    ha = NONE; hb = NONE; nr = NONE;
    mode = 1'b0; target = 8'h10; nonce_base = '0; nonce_base8 = '0;
    lane_hash = '0; lane_hash8 = '1; lane_done = 1'b0; lane_done8 = 1'b0;
    cnt = 0; cnt8 = 0;
    do_reset();

    // Reset state of both instances
    chk("rst lane_start", lane_start, 1'b0);
    chk("rst lane_nonce", lane_nonce, '0);
    chk("rst outputs", {terminado, exhausted, hash_out, nonce_out, batches}, '0);
    chk("rst8 outputs", {lane_start8, lane_nonce8, terminado8, exhausted8,
                         hash_out8, nonce_out8, batches8}, '0);

    // Table-driven stop-on-first searches
    for (int v = 0; v < 5; v++) begin
      do_reset();
      ha = vecs[v].ha; hb = vecs[v].hb; nr = vecs[v].nr;
      nonce_base = vecs[v].base; target = vecs[v].tgt; mode = 1'b0;
      active = 1'b1;
      tick();
      chk($sformatf("v%0d start pulse", v), lane_start, 1'b1);
      chk($sformatf("v%0d first nonces", v), lane_nonce, vecs[v].exp_first);
      chk($sformatf("v%0d first batch count", v), batches, 32'd1);
      if (vecs[v].exp_hit) begin
        wait_term($sformatf("v%0d terminado", v));
        chk($sformatf("v%0d nonceOut", v), nonce_out, vecs[v].exp_nonce);
        chk($sformatf("v%0d hashOut", v), hash_out, vecs[v].exp_hash);
        chk($sformatf("v%0d batches", v), batches, vecs[v].exp_batches);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        tick();
        chk($sformatf("v%0d mode0 ack ignored", v), terminado, 1'b1);
        chk($sformatf("v%0d hold no launch", v), lane_start, 1'b0);
        active = 1'b0;
        tick(); tick();
        chk($sformatf("v%0d abort clears", v), terminado, 1'b0);
        chk($sformatf("v%0d nonceOut kept", v), nonce_out, vecs[v].exp_nonce);
      end else begin
        nb = 0;
        while (batches < 32'd4 && nb < 200) begin tick(); nb++; end
        chk($sformatf("v%0d reached batch 4", v), batches, 32'd4);
        chk($sformatf("v%0d no hit", v), {terminado, exhausted}, 2'b00);
        active = 1'b0;
        tick(); tick();
      end
    end

    // Continuous mode: two hits in one batch, reported in lane order
    do_reset();
    ha = 32'h08; hb = 32'h0A; nr = NONE;
    nonce_base = 32'h08; target = 8'h10; mode = 1'b1;
    active = 1'b1;
    tick();
    chk("m1 first nonces", lane_nonce, {32'h0B, 32'h0A, 32'h09, 32'h08});
    wait_done("m1 lane_done");
    chk("m1 not yet", terminado, 1'b0);
    tick();
    chk("m1 hit latency", terminado, 1'b1);
    chk("m1 nonce 8", nonce_out, 32'h08);
    chk("m1 hash 8", hash_out, 24'h0F0F08);
    tick();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk("m1 ack clears", terminado, 1'b0);
    tick();
    chk("m1 second hit", terminado, 1'b1);
    chk("m1 nonce 10", nonce_out, 32'h0A);
    chk("m1 hash 10", hash_out, 24'h0E000A);
    chk("m1 no new batch", {lane_start, batches}, {1'b0, 32'd1});
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk("m1 ack2 clears", terminado, 1'b0);
    tick();
    chk("m1 next launch", lane_start, 1'b1);
    chk("m1 next base", lane_nonce[31:0], 32'h0C);
    chk("m1 batches", batches, 32'd2);
    active = 1'b0;
    mode = 1'b0;
    tick(); tick();

    // Exhaustion on the 8-bit instance
    do_reset();
    nonce_base8 = 8'hF0; target = 8'h10;
    active8 = 1'b1;
    starts = 0; t = 0; t_done = -100; t_exh = -1; last8 = '0;
    while (exhausted8 !== 1'b1 && t < 200) begin
      tick();
      t++;
      if (lane_start8) begin starts++; last8 = lane_nonce8; end
      if (lane_done8) t_done = t;
      if (exhausted8) t_exh = t;
    end
    chk("ex flag", exhausted8, 1'b1);
    chk("ex latency", t_exh - t_done, 1);
    chk("ex batches seen", starts, 4);
    chk("ex last nonces", last8, {8'hFF, 8'hFE, 8'hFD, 8'hFC});
    chk("ex batches", batches8, 32'd4);
    chk("ex no hit", terminado8, 1'b0);
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (lane_start8) starts++;
    end
    chk("ex no wrap", starts, 0);
    chk("ex held", exhausted8, 1'b1);
    active8 = 1'b0;
    tick(); tick();
    chk("ex cleared", exhausted8, 1'b0);

    // Abort in WAIT, late lane_done ignored, then restart
    do_reset();
    ha = 32'h02; hb = NONE; nr = NONE;
    nonce_base = 32'h00; target = 8'h10; mode = 1'b0;
    active = 1'b1;
    tick();
    chk("ab start", lane_start, 1'b1);
    tick();
    active = 1'b0;
    wait_done("ab late done");
    tick(); tick(); tick();
    chk("ab idle", {terminado, lane_start, exhausted}, 3'b000);
    chk("ab batches", batches, 32'd1);
    ha = 32'h41;
    nonce_base = 32'h40;
    active = 1'b1;
    tick();
    chk("ab restart", lane_start, 1'b1);
    chk("ab restart nonces", lane_nonce, {32'h43, 32'h42, 32'h41, 32'h40});
    chk("ab restart batches", batches, 32'd2);
    wait_term("ab terminado");
    chk("ab nonceOut", nonce_out, 32'h41);

    // Asynchronous reset while in HIT
    #3;
    reset = 1'b1;
    #1;
    chk("rh outputs zero", {lane_start, terminado, exhausted, hash_out, nonce_out, batches}, '0);
    chk("rh lane_nonce zero", lane_nonce, '0);
    active = 1'b0;
    #2;
    reset = 1'b0;
    tick(); tick(); tick();
    chk("rh waits", {lane_start, batches}, '0);
    active = 1'b1;
    tick();
    chk("rh restart", {lane_start, batches}, {1'b1, 32'd1});
    active = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sistema_scan.md
# sistema_scan

Parametrised nonce-search controller, successor to the fixed-width `sistema_speed` search loop. It issues batches of consecutive nonces to `LANES` external hash lanes and latches the returned hashes. Each hash is checked against an 8-bit target over a configurable number of leading hash bytes. Results are reported in either stop-on-first or continuous mode, and exhaustion of the nonce space is flagged. It sits between the top-level mining control and the array of micro-hash lanes.

## Interface
- `LOG_LANES`, 3: LANES = 2^LOG_LANES parallel hash lanes (1..7).
- `NONCE_W`, 32: nonce width, must exceed LOG_LANES.
- `HASH_W`, 24: hash width, multiple of 8.
- `CMP_BYTES`, 2: number of most-significant hash bytes compared against `target`, 1..HASH_W/8.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `active` in 1: level; search runs while high, low aborts.
- `mode` in 1: 0 = stop on first hit; 1 = continuous, resume after `result_ack`.
- `target` in 8: captured at search start.
- `nonce_base` in NONCE_W: start nonce, captured at search start; low LOG_LANES bits forced to 0.
- `result_ack` in 1: single-cycle pulse; meaningful only in HIT with mode 1.
- `lane_start` out 1: one-cycle pulse launching a batch.
- `lane_nonce` out LANES*NONCE_W: lane i nonce in slice i, valid from `lane_start` until `lane_done`.
- `lane_done` in 1: one-cycle pulse, all lane hashes valid.
- `lane_hash` in LANES*HASH_W: lane i hash in slice i.
- `terminado` out 1: result valid.
- `hashOut` out HASH_W: hitting hash.
- `nonceOut` out NONCE_W: hitting nonce.
- `exhausted` out 1: nonce space searched to top with no pending hit.
- `batches` out 32: count of issued batches, wraps.

## Operation
- States: IDLE, ISSUE, WAIT, CHECK, HIT, EXHAUST.
- Reset: state IDLE; all outputs 0, including `lane_nonce`, `hashOut`, `nonceOut` and `batches`.
- IDLE + `active`=1: capture `target`, `mode` and aligned `base`, then go to ISSUE.
- ISSUE: assert `lane_start` for one cycle. `lane_nonce[i]` = base + i. `batches`++. Go to WAIT.
- WAIT: on `lane_done`, register all lane hashes. Set `hit_mask[i]` = 1 iff every one of the top CMP_BYTES bytes of hash i is strictly below `target`. Go to CHECK.
- CHECK: if `hit_mask` ≠ 0, pick the lowest i, load `hashOut` = hash i, `nonceOut` = base + i, set `terminado`, and go to HIT.
- CHECK with no hit:
  - if base = 2^NONCE_W − LANES, set `exhausted` and go to EXHAUST;
  - else base += LANES and go to ISSUE.
- The search never wraps; it runs ascending from `nonce_base` to the top of the nonce space.
- HIT, mode 0: hold outputs until `active` falls.
- HIT, mode 1: on `result_ack`, clear `terminado`, clear the reported `hit_mask` bit, and go to CHECK. Remaining hits in the same batch are reported in ascending lane order before the next batch is issued.
- EXHAUST: hold until `active` falls.
- `active`=0 in any non-IDLE state: next state IDLE. `terminado` and `exhausted` clear; `hashOut` and `nonceOut` keep their last values. A `lane_done` that arrives in IDLE is ignored.
- `target` = 0 never hits.
- `result_ack` outside HIT, or while mode = 0, is ignored.

## Timing
- Start: `active` first sampled high at edge n in IDLE → `lane_start` high during cycle n+1.
- Hit report: `lane_done` sampled at edge m → `terminado` high from cycle m+2.
- No-hit rollover: `lane_done` at edge m → next `lane_start` in cycle m+2, giving per-batch overhead of 3 cycles plus lane latency.
- Ack: `result_ack` at edge k → `terminado` low in cycle k+1. The next hit in the same batch asserts `terminado` in cycle k+2.
- `exhausted` rises in the same cycle `terminado` would have.
- Outputs are registered; no combinational paths from inputs to outputs.
- Asynchronous `reset` mid-batch: immediate return to IDLE with all outputs 0.

## Structure
- Shared package holds state encoding, the LANES/width localparams, and the hash-vs-target compare function.
- One sub-module, `scan_hit_pick`: priority encoder over `hit_mask` returning a found flag and the lowest index.
- Lanes remain external; this block contains no hash logic.

## Test plan
Configuration for all scenarios: LOG_LANES=2, CMP_BYTES=2, and a bench lane model with 5-cycle latency.
- Base 0, target 0x10, only nonce 6 hashes to 0x0F0Fxx → `terminado` after batch 2, `nonceOut`=6, `batches`=2.
- Mode 1, nonces 8 and 10 hit in the same batch → report 8, ack, report 10 with no new `lane_start` in between, ack, then continue with nonce 12.
- NONCE_W=8, base 0xF0, no hits → `exhausted`=1 after 4 batches, last batch nonces 0xFC–0xFF, no wrap.
- `nonce_base`=0x13 → first `lane_nonce` values are 0x10–0x13.
- Drop `active` in WAIT, then raise `lane_done` → remains IDLE, no `terminado`. Restart with base 0x40 → fresh batch at 0x40.
- Assert `reset` while in HIT → all outputs 0 immediately. After release, IDLE waits for `active`.
